// File: rtl/reg_writeback_sequencer.sv
// reg_writeback_sequencer: queues execute/memory results and issues them as register-file write beats.
// Optional build macro WB_FWD_EN adds the fwd_valid1/2 and fwd_data1/2 forwarding outputs.
// Ports:
//   clk, reset (sync, active-high).
//   wb_* : upstream result handshake; kind 00 none, 01 R0 only, 10 Rd only, 11 Rd then R0.
//   write_reg/write_data/r0/reg_write : write-port beats (11 Rd, 01 R0, 00 idle).
//   read_reg1/2 -> hazard1/2 : decode-stage hazard check against pending writes.
//   busy : queue non-empty or a beat is presented.
// Latency is one cycle from accept into an empty queue to the first beat.
// wb_ready is deasserted while the queue holds DEPTH entries.
module reg_writeback_sequencer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [1:0]  wb_kind,
  input  logic [3:0]  wb_rd,
  input  logic [15:0] wb_data,
  input  logic [15:0] wb_r0_data,
  output logic [4:0]  write_reg,
  output logic [15:0] write_data,
  output logic [15:0] r0,
  output logic [1:0]  reg_write,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  output logic        hazard1,
  output logic        hazard2,
  output logic        busy
`ifdef WB_FWD_EN
  ,
  output logic        fwd_valid1,
  output logic        fwd_valid2,
  output logic [15:0] fwd_data1,
  output logic [15:0] fwd_data2
`endif
);

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  rd;
    logic [15:0] data;
    logic [15:0] r0_data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BEAT_RD = 2'd1,
    BEAT_R0 = 2'd2
  } state_t;

  // Storage is sized for the largest legal DEPTH so 2-bit pointers index it cleanly.
  entry_t     mem [0:3];
  logic [1:0] rd_ptr, wr_ptr, rd_ptr_adv;
  logic [2:0] count, count_next;
  state_t     state, state_next;

  entry_t     head, in_entry, nxt_head, beat_src;
  logic       push, pop, last_beat;
  logic       continue_r0;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign wb_ready = (count != 3'(DEPTH));
  assign head     = mem[rd_ptr];
  assign in_entry = '{kind: wb_kind, rd: wb_rd, data: wb_data, r0_data: wb_r0_data};

  // The head entry stays queued while its beats are presented; it pops at the
  // edge that ends its last beat, so queued entries are exactly the pending ones.
  always_comb begin
    last_beat   = 1'b0;
    continue_r0 = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    rd_ptr_adv  = rd_ptr;
    count_next  = count;
    nxt_head    = in_entry;
    beat_src    = in_entry;
    state_next  = IDLE;

    continue_r0 = (state == BEAT_RD) && (head.kind == 2'b11);
    last_beat   = (state == BEAT_R0) || ((state == BEAT_RD) && !continue_r0);
    pop         = last_beat;
    push        = wb_valid && wb_ready && (wb_kind != 2'b00);
    rd_ptr_adv  = pop ? wrap_inc(rd_ptr) : rd_ptr;
    count_next  = count + {2'b00, push} - {2'b00, pop};

    // Next entry to present: the remaining queue head, or the incoming result
    // when the queue would otherwise be empty (one-cycle latency path).
    if ((count - {2'b00, pop}) != 3'd0) nxt_head = mem[rd_ptr_adv];
    else                                nxt_head = in_entry;

    if (continue_r0) begin
      state_next = BEAT_R0;
      beat_src   = head;
    end else if (count_next != 3'd0) begin
      state_next = nxt_head.kind[1] ? BEAT_RD : BEAT_R0;
      beat_src   = nxt_head;
    end else begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= wrap_inc(wr_ptr);
      end
      rd_ptr <= rd_ptr_adv;
      count  <= count_next;
    end
  end

  // Beat registers: address/data hold their last beat's value between beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write  <= 2'b00;
      write_reg  <= 5'd0;
      write_data <= 16'd0;
      r0         <= 16'd0;
      busy       <= 1'b0;
    end else begin
      busy <= (count_next != 3'd0);
      case (state_next)
        BEAT_RD: begin
          reg_write  <= 2'b11;
          write_reg  <= {1'b0, beat_src.rd};
          write_data <= beat_src.data;
        end
        BEAT_R0: begin
          reg_write <= 2'b01;
          r0        <= beat_src.r0_data;
        end
        default: reg_write <= 2'b00;
      endcase
    end
  end

  // Hazards scan oldest to youngest so a later match overwrites the forwarded
  // value; within one entry the R0 beat follows the Rd beat.
  always_comb begin
    entry_t     e;
    logic [2:0] s;
    logic       rd_pend, r0_pend, m1_rd, m1_r0, m2_rd, m2_r0;
    e       = '0;
    s       = 3'd0;
    rd_pend = 1'b0;
    r0_pend = 1'b0;
    m1_rd   = 1'b0;
    m1_r0   = 1'b0;
    m2_rd   = 1'b0;
    m2_r0   = 1'b0;
    hazard1 = 1'b0;
    hazard2 = 1'b0;
`ifdef WB_FWD_EN
    fwd_valid1 = 1'b0;
    fwd_valid2 = 1'b0;
    fwd_data1  = 16'd0;
    fwd_data2  = 16'd0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count)) begin
        s = {1'b0, rd_ptr} + 3'(i);
        if (s >= 3'(DEPTH)) s = s - 3'(DEPTH);
        e = mem[s[1:0]];
        // The head's Rd beat has retired once it is presenting its R0 beat.
        rd_pend = e.kind[1] && !((i == 0) && (state == BEAT_R0));
        r0_pend = e.kind[0];
        m1_rd   = rd_pend && (read_reg1 == {1'b0, e.rd});
        m1_r0   = r0_pend && (read_reg1 == 5'd0);
        m2_rd   = rd_pend && (read_reg2 == {1'b0, e.rd});
        m2_r0   = r0_pend && (read_reg2 == 5'd0);
        if (m1_rd || m1_r0) hazard1 = 1'b1;
        if (m2_rd || m2_r0) hazard2 = 1'b1;
`ifdef WB_FWD_EN
        if (m1_rd) fwd_data1 = e.data;
        if (m1_r0) fwd_data1 = e.r0_data;
        if (m2_rd) fwd_data2 = e.data;
        if (m2_r0) fwd_data2 = e.r0_data;
`endif
      end
    end
`ifdef WB_FWD_EN
    fwd_valid1 = hazard1;
    fwd_valid2 = hazard2;
`endif
  end

endmodule

// File: tb/tb_reg_writeback_sequencer.sv
// Self-checking bench for reg_writeback_sequencer (DEPTH=2): table of per-cycle
// vectors plus hand-written sequences for forwarding and mid-sequence reset.
module tb_reg_writeback_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [1:0]  wb_kind;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data, wb_r0_data;
  logic [4:0]  write_reg;
  logic [15:0] write_data, r0;
  logic [1:0]  reg_write;
  logic [4:0]  read_reg1, read_reg2;
  logic        hazard1, hazard2, busy;
`ifdef WB_FWD_EN
  logic        fwd_valid1, fwd_valid2;
  logic [15:0] fwd_data1, fwd_data2;
`endif

  always #5 clk = ~clk;

  reg_writeback_sequencer #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_kind(wb_kind), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_r0_data(wb_r0_data),
    .write_reg(write_reg), .write_data(write_data), .r0(r0), .reg_write(reg_write),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .hazard1(hazard1), .hazard2(hazard2), .busy(busy)
`ifdef WB_FWD_EN
    , .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  k;
    logic [3:0]  rd;
    logic [15:0] d, r0d;
    logic [4:0]  rr1, rr2;
    logic [1:0]  rw;
    logic [4:0]  wreg;
    logic [15:0] wd, r0v;
    logic        rdy, bsy, h1, h2;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [1:0] k, input logic [3:0] rd,
                     input logic [15:0] d, input logic [15:0] r0d,
                     input logic [4:0] rr1, input logic [4:0] rr2,
                     input logic [1:0] rw, input logic [4:0] wreg,
                     input logic [15:0] wd, input logic [15:0] r0v,
                     input logic rdy, input logic bsy, input logic h1, input logic h2);
    vec_t t;
    t = '{v, k, rd, d, r0d, rr1, rr2, rw, wreg, wd, r0v, rdy, bsy, h1, h2};
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic [1:0] k, input logic [3:0] rd,
                       input logic [15:0] d, input logic [15:0] r0d,
                       input logic [4:0] rr1, input logic [4:0] rr2);
    wb_valid = v; wb_kind = k; wb_rd = rd; wb_data = d; wb_r0_data = r0d;
    read_reg1 = rr1; read_reg2 = rr2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each row: inputs for this cycle and the outputs expected in the same cycle.
    // Data fields are checked only when the expected beat presents them.
    add(0,2'b00,0,16'h0000,16'h0000, 0, 0, 2'b00,0,16'h0000,16'h0000, 1,0,0,0);
    add(1,2'b10,5,16'h1234,16'h0000, 5, 0, 2'b00,0,16'h0000,16'h0000, 1,0,0,0);
    add(0,2'b00,0,16'h0000,16'h0000, 5, 7, 2'b11,5,16'h1234,16'h0000, 1,1,1,0);
    add(0,2'b00,0,16'h0000,16'h0000, 5, 0, 2'b00,0,16'h0000,16'h0000, 1,0,0,0);
    add(1,2'b11,3,16'hAAAA,16'h0001, 3, 0, 2'b00,0,16'h0000,16'h0000, 1,0,0,0);
    add(1,2'b11,9,16'h5555,16'h0002, 3, 0, 2'b11,3,16'hAAAA,16'h0000, 1,1,1,1);
    add(1,2'b10,2,16'h0BEE,16'h0000, 3, 9, 2'b01,0,16'h0000,16'h0001, 0,1,0,1);
    add(1,2'b10,2,16'h0BEE,16'h0000, 0, 2, 2'b11,9,16'h5555,16'h0000, 1,1,1,0);
    add(0,2'b00,0,16'h0000,16'h0000, 2, 9, 2'b01,0,16'h0000,16'h0002, 0,1,1,0);
    add(1,2'b00,4,16'hDEAD,16'h0000, 2, 4, 2'b11,2,16'h0BEE,16'h0000, 1,1,1,0);
    add(1,2'b01,0,16'h0000,16'h00C0, 0, 4, 2'b00,0,16'h0000,16'h0000, 1,0,0,0);
    add(1,2'b10,0,16'h0D00,16'h0000, 0, 1, 2'b01,0,16'h0000,16'h00C0, 1,1,1,0);
    add(1,2'b10,7,16'h7777,16'h0000, 7, 0, 2'b11,0,16'h0D00,16'h0000, 1,1,0,1);
    add(0,2'b00,0,16'h0000,16'h0000, 7, 0, 2'b11,7,16'h7777,16'h0000, 1,1,1,0);
    add(1,2'b11,0,16'h1111,16'h2222, 0,16, 2'b00,0,16'h0000,16'h0000, 1,0,0,0);
    add(0,2'b00,0,16'h0000,16'h0000, 0,16, 2'b11,0,16'h1111,16'h0000, 1,1,1,0);
    add(0,2'b00,0,16'h0000,16'h0000, 0,16, 2'b01,0,16'h0000,16'h2222, 1,1,1,0);
    add(0,2'b00,0,16'h0000,16'h0000, 0,16, 2'b00,0,16'h0000,16'h0000, 1,0,0,0);

    reset = 1'b1;
    drive(0, 2'b00, 0, 16'h0, 16'h0, 0, 0);
    next_cycle();
    next_cycle();
    chk("reset reg_write",  32'(reg_write),  32'h0);
    chk("reset write_reg",  32'(write_reg),  32'h0);
    chk("reset write_data", 32'(write_data), 32'h0);
    chk("reset r0",         32'(r0),         32'h0);
    chk("reset wb_ready",   32'(wb_ready),   32'h1);
    chk("reset busy",       32'(busy),       32'h0);
    chk("reset hazard1",    32'(hazard1),    32'h0);
    reset = 1'b0;

    foreach (vecs[n]) begin
      drive(vecs[n].v, vecs[n].k, vecs[n].rd, vecs[n].d, vecs[n].r0d, vecs[n].rr1, vecs[n].rr2);
      #4;
      chk($sformatf("row%0d reg_write", n), 32'(reg_write), 32'(vecs[n].rw));
      if (vecs[n].rw == 2'b11) begin
        chk($sformatf("row%0d write_reg", n),  32'(write_reg),  32'(vecs[n].wreg));
        chk($sformatf("row%0d write_data", n), 32'(write_data), 32'(vecs[n].wd));
      end
      if (vecs[n].rw == 2'b01)
        chk($sformatf("row%0d r0", n), 32'(r0), 32'(vecs[n].r0v));
      chk($sformatf("row%0d wb_ready", n), 32'(wb_ready), 32'(vecs[n].rdy));
      chk($sformatf("row%0d busy", n),     32'(busy),     32'(vecs[n].bsy));
      chk($sformatf("row%0d hazard1", n),  32'(hazard1),  32'(vecs[n].h1));
      chk($sformatf("row%0d hazard2", n),  32'(hazard2),  32'(vecs[n].h2));
      next_cycle();
    end

    // Pending Rd write to R7: hazard on port 1 only, forwarded value when enabled.
    drive(1, 2'b10, 7, 16'h7A7A, 16'h0, 7, 0);
    next_cycle();
    drive(0, 2'b00, 0, 16'h0, 16'h0, 7, 0);
    #4;
    chk("fwd7 hazard1", 32'(hazard1), 32'h1);
    chk("fwd7 hazard2", 32'(hazard2), 32'h0);
`ifdef WB_FWD_EN
    chk("fwd7 fwd_valid1", 32'(fwd_valid1), 32'h1);
    chk("fwd7 fwd_data1",  32'(fwd_data1),  32'h7A7A);
    chk("fwd7 fwd_valid2", 32'(fwd_valid2), 32'h0);
    chk("fwd7 fwd_data2",  32'(fwd_data2),  32'h0);
`endif
    next_cycle();
    next_cycle();

`ifdef WB_FWD_EN
    // R0 read with a kind 11 rd=0 pending: R0 data is the youngest value.
    drive(1, 2'b11, 0, 16'h0A0A, 16'h0B0B, 0, 0);
    next_cycle();
    drive(0, 2'b00, 0, 16'h0, 16'h0, 0, 0);
    #4;
    chk("fwd0 fwd_data1", 32'(fwd_data1), 32'h0B0B);
    next_cycle();
    next_cycle();
    next_cycle();
`endif

    // Reset asserted during the Rd beat of a kind 11: the R0 beat must never appear.
    drive(1, 2'b11, 4, 16'h4444, 16'h5555, 0, 4);
    next_cycle();
    drive(0, 2'b00, 0, 16'h0, 16'h0, 0, 4);
    #4;
    chk("midrst rd beat",   32'(reg_write), 32'h3);
    chk("midrst write_reg", 32'(write_reg), 32'h4);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #4;
    chk("midrst reg_write",  32'(reg_write),  32'h0);
    chk("midrst write_reg0", 32'(write_reg),  32'h0);
    chk("midrst write_data", 32'(write_data), 32'h0);
    chk("midrst r0",         32'(r0),         32'h0);
    chk("midrst busy",       32'(busy),       32'h0);
    chk("midrst wb_ready",   32'(wb_ready),   32'h1);
    chk("midrst hazard1",    32'(hazard1),    32'h0);
    chk("midrst hazard2",    32'(hazard2),    32'h0);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      #4;
      chk($sformatf("postrst%0d reg_write", c), 32'(reg_write), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
